// File: rtl/shift_add_mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package shift_add_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/simple_adder.sv
// Plain WIDTH-bit unsigned adder with carry out.
module simple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add unsigned multiplier: one adder reused once per multiplier bit.
// Optional macro SHIFT_ADD_MULT_SEQ_EARLY_EXIT_EN stops as soon as the remaining multiplier bits are zero.
module shift_add_mult_seq
  import shift_add_mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [2*WIDTH-1:0]     p_q, p_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  logic [WIDTH-1:0]       add_b;
  logic [WIDTH-1:0]       sum;
  logic                   cout;
  logic [2*WIDTH-1:0]     p_step;
  logic [CNT_W-1:0]       cnt_step;
  logic [2*WIDTH-1:0]     product_step;
  logic                   last_step;

  assign add_b = p_q[0] ? mcand_q : '0;

  simple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (p_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .sum  (sum),
    .cout (cout)
  );

  // The carry becomes the new MSB as the whole register shifts right.
  assign p_step   = {cout, sum, p_q[WIDTH-1:1]};
  assign cnt_step = cnt_q + CNT_W'(1);

`ifdef SHIFT_ADD_MULT_SEQ_EARLY_EXIT_EN
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] pending_mask;

  // Unprocessed multiplier bits occupy the low WIDTH-cnt bits of P.
  assign ones         = '1;
  assign pending_mask = ones >> cnt_step;
  assign last_step    = (p_step[WIDTH-1:0] & pending_mask) == '0;
  assign product_step = p_step >> (CNT_W'(WIDTH) - cnt_step);
`else
  assign last_step    = (cnt_step == CNT_W'(WIDTH));
  assign product_step = p_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
        end
      end
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_step;
        if (last_step) product_d = product_step;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Self-checking bench for shift_add_mult_seq (WIDTH=8) using an expected-result queue.
module tb_shift_add_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int          n_cmp;
  int          n_err;
  logic [15:0] sb[$];

  shift_add_mult_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_steps(input logic [7:0] mb);
    int n;
`ifdef SHIFT_ADD_MULT_SEQ_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 8; i++) if (mb[i]) n = i + 1;
`else
    n = 8;
`endif
    return n;
  endfunction

  // Called at the negedge right after the accept edge.
  task automatic recv(input logic [7:0] mb, input int stall);
    int          k;
    logic [15:0] e;
    k = 0;
    chk("in_ready_run", 32'(in_ready), 32'd0);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(exp_steps(mb)));
    e = sb.pop_front();
    chk("product", 32'(product), 32'(e));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_product", 32'(product), 32'(e));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_exit", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("product_held", 32'(product), 32'(e));
  endtask

  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_, input int stall, input bit hold);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb_;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    sb.push_back({8'd0, ta} * {8'd0, tb_});
    @(negedge clk);
    if (hold) begin
      a = 8'd9;
      b = 8'd9;
    end else begin
      in_valid = 1'b0;
    end
    recv(tb_, stall);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(8'd13, 8'd11, 0, 1'b0);
    run_txn(8'd255, 8'd255, 0, 1'b0);
    run_txn(8'd0, 8'd200, 0, 1'b0);
    run_txn(8'd6, 8'd7, 5, 1'b0);

    // Operands held valid during RUN must only be taken once back in IDLE.
    run_txn(8'd4, 8'd5, 0, 1'b1);
    sb.push_back(16'd81);
    @(negedge clk);
    in_valid = 1'b0;
    recv(8'd9, 0);

    // Reset in the middle of a computation discards it.
    @(negedge clk);
    a        = 8'd100;
    b        = 8'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'd3, 8'd4, 0, 1'b0);

    run_txn(8'd200, 8'd3, 0, 1'b0);
    run_txn(8'd77, 8'd0, 0, 1'b0);
    run_txn(8'd5, 8'd128, 0, 1'b0);
    run_txn(8'd171, 8'd93, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
